trans_est: RTL
==============

# trans_est

Per-pixel transmission estimator for the haze-removal pipeline, directly downstream of atmospheric light estimation. Consumes the 3x3 dark-channel minimum and the current atmospheric light A, and produces the 8-bit transmission t = 255·(1 − ω·dark/A) using a bit-serial restoring divider. A valid/ready handshake on both sides lets it stall against the scene-recovery stage.

## Interface
- OMEGA, 243: haze-retention factor ω as a fraction of 256 (243 ≈ 0.95).
- T_MIN, 26: lower clamp on t (≈ 0.1·255); used only when the clamp is compiled in.
- clock  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  dark/A operands are valid.
- in_ready  out  1  block can accept operands (IDLE only).
- dark  in  8  dark-channel minimum of the 3x3 window.
- A  in  8  atmospheric light.
- out_valid  out  1  t is valid; held until accepted.
- out_ready  in  1  downstream accepts t.
- t  out  8  transmission value.

## Operation
- FSM states: IDLE, DIV, SCALE, OUT.
- IDLE: in_ready=1. On in_valid && in_ready, register dark and A, set sat = (dark >= A), clear quotient/remainder and iteration counter, go to DIV.
- DIV: restoring division of {dark, 8'h00} (16-bit) by A, one quotient bit per cycle, MSB first, with a 3-bit counter covering 8 iterations; then go to SCALE. The divider always runs 8 cycles, including when sat=1, so latency is fixed.
- SCALE: q = sat ? 255 : quotient[7:0]; p = OMEGA·q (16-bit); t_raw = 255 − p[15:8]. Register t and go to OUT.
- OUT: out_valid=1 and t is held stable. On out_ready, go to IDLE.
- A = 0 always sets sat (dark ≥ 0), so there is no divide-by-zero path. Result: q = 255.
- Every intermediate is unsigned. t_raw never underflows because p[15:8] ≤ 242.
- Inputs are sampled only on the accept edge. Changes to dark, A or in_valid while busy are ignored.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, t=8'd0, quotient, remainder and counter = 0.
- Accept at edge k. DIV occupies edges k+1..k+8, SCALE is edge k+9, and out_valid=1 from edge k+10. Latency is 10 cycles.
- In OUT with out_ready=1, the handshake completes at that edge: out_valid=0 and in_ready=1 after it.
- A new operand is accepted no earlier than the cycle after the output handshake, giving a minimum of 12 cycles per result.
- out_ready held low: OUT persists indefinitely and t does not change.
- out_ready high before OUT has no effect.
- Reset asserted in any state, including mid-DIV: the next edge returns every register to its reset value and the in-flight result is discarded.
- in_valid and out_ready are never simultaneously effective, since in_ready=0 in OUT.

## Configuration
- TRANS_CLAMP_EN defined: SCALE registers t = max(t_raw, T_MIN).
- TRANS_CLAMP_EN undefined: t = t_raw, and T_MIN is unused.

## Test plan
- Reset then dark=90, A=180, out_ready=1: in_ready drops after accept, out_valid rises exactly 10 cycles later with t=134, and in_ready returns the cycle after the handshake.
- dark=200, A=180 (saturation): q=255 and t_raw=13. Output is t=26 with TRANS_CLAMP_EN and t=13 without.
- dark=0, A=255 gives t=255. dark=0, A=0 gives t=26 with the clamp and 13 without, with no X/Z on any output.
- Backpressure: dark=90, A=180 with out_ready=0 for 20 cycles. out_valid stays 1, t stays 134, and in_valid pulses are ignored. Raising out_ready completes exactly one transfer.
- Reset asserted 4 cycles into DIV: after the next edge out_valid=0, in_ready=1 and t=0. A following dark=90, A=180 yields t=134 with the full 10-cycle latency.
- Back-to-back stream of 50 random (dark, A) pairs with in_valid held high and out_ready=1: each t matches the reference model 255 − ((OMEGA·q)>>8) (clamped if enabled), in order, with one result every 12 cycles.

Source files
------------

// File: rtl/trans_est.sv
// Per-pixel transmission estimator: t = 255*(1 - omega*dark/A) via an 8-step restoring divider.
// Optional lower clamp of t to T_MIN is compiled in with `define TRANS_CLAMP_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | in_ready high, waiting for an operand pair
// S_DIV   | one quotient bit per cycle, 8 cycles regardless of saturation
// S_SCALE | apply omega and register t
// S_OUT   | first cycle arms out_valid, then hold t until out_ready

module trans_est #(
    parameter int unsigned OMEGA = 243,
    parameter int unsigned T_MIN = 26
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [7:0] dark_i,
    input  logic [7:0] a_i,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic [7:0] t_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_SCALE,
        S_OUT
    } state_t;

    localparam logic [7:0] OMEGA_B = 8'(OMEGA);
    localparam logic [7:0] T_MIN_B = 8'(T_MIN);
`ifdef TRANS_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    state_t     state_q;
    logic [7:0] dark_q;
    logic [7:0] a_q;
    logic       sat_q;
    logic [7:0] quot_q;
    logic [8:0] rem_q;
    logic [2:0] cnt_q;
    logic [7:0] t_q;
    logic       in_ready_q;
    logic       out_valid_q;

    logic [8:0] rem_base;
    logic [9:0] rem_shift;
    logic       rem_ge;
    logic [8:0] rem_next;
    logic [7:0] q_sel;
    logic [7:0] p_hi;
    logic [7:0] t_raw;
    logic [7:0] t_fin;

    // The low dividend byte is zero and dark < A when not saturated, so the first
    // eight quotient bits are zero and the partial remainder enters as dark itself.
    always_comb begin
        rem_base  = (cnt_q == 3'd0) ? {1'b0, dark_q} : rem_q;
        rem_shift = {rem_base, 1'b0};
        rem_ge    = (rem_shift >= {2'b00, a_q});
        rem_next  = rem_ge ? 9'(rem_shift - {2'b00, a_q}) : rem_shift[8:0];
    end

    always_comb begin
        q_sel = sat_q ? 8'hFF : quot_q;
        p_hi  = 8'(({8'd0, OMEGA_B} * {8'd0, q_sel}) >> 8);
        t_raw = 8'd255 - p_hi;
        t_fin = (CLAMP_EN && (t_raw < T_MIN_B)) ? T_MIN_B : t_raw;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            dark_q      <= 8'd0;
            a_q         <= 8'd0;
            sat_q       <= 1'b0;
            quot_q      <= 8'd0;
            rem_q       <= 9'd0;
            cnt_q       <= 3'd0;
            t_q         <= 8'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid_i && in_ready_q) begin
                        dark_q     <= dark_i;
                        a_q        <= a_i;
                        sat_q      <= (dark_i >= a_i);
                        quot_q     <= 8'd0;
                        rem_q      <= 9'd0;
                        cnt_q      <= 3'd0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_DIV;
                    end
                end
                S_DIV: begin
                    rem_q  <= rem_next;
                    quot_q <= {quot_q[6:0], rem_ge};
                    cnt_q  <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_q <= S_SCALE;
                    end
                end
                S_SCALE: begin
                    t_q     <= t_fin;
                    state_q <= S_OUT;
                end
                S_OUT: begin
                    // Arming out_valid one cycle into OUT fixes the latency at 10 cycles.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign t_o         = t_q;

endmodule
